seg_scan_capture: RTL and testbench

- Receive end of the multiplexed seven-segment display interface that the CPU top drives on SEG/AN.
- Samples the scanned AN/SEG lines, debounces each scan slot, and decodes each glyph back to a hex nibble.
- Reassembles the 8-digit, 32-bit displayed value, with a per-frame completion pulse and sticky error flags.
- Used in simulation benches and on-board self-check to read back what the core displays, with no dependency on scan rate.

---
 rtl/seg_scan_capture.sv | 139 +++++++++++++
 tb/tb_seg_scan_capture.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: receive end of a multiplexed 7-segment display scan.
// Samples AN/SEG, waits for a slot to hold still for STABLE_CYCLES clocks,
// decodes the glyph back to a hex nibble and reassembles the 8-digit value.
module seg_scan_capture #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        RST,
   input  logic [7:0]  SEG,
   input  logic [7:0]  AN,
   output logic [31:0] value,
   output logic [7:0]  dp,
   output logic [7:0]  digit_seen,
   output logic [31:0] frame_value,
   output logic        frame_done,
   output logic        seg_error,
   output logic        an_error
);

   localparam int CNT_W = 8;

   logic [7:0]       s_an_q, s_seg_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      value_q, value_d;
   logic [7:0]       dp_q, dp_d;
   logic [7:0]       seen_q, seen_d;
   logic [31:0]      fvalue_q, fvalue_d;
   logic             fdone_q, fdone_d;
   logic             seg_err_q, seg_err_d;
   logic             an_err_q, an_err_d;

   logic             changed, latch, an_onehot, an_blank;
   logic [2:0]       idx;
   logic [4:0]       dec;

   // glyph (gfedcba, active-high) to {hit, nibble}
   function automatic logic [4:0] decode(input logic [6:0] g);
      case (g)
         7'h3F:   return {1'b1, 4'h0};
         7'h06:   return {1'b1, 4'h1};
         7'h5B:   return {1'b1, 4'h2};
         7'h4F:   return {1'b1, 4'h3};
         7'h66:   return {1'b1, 4'h4};
         7'h6D:   return {1'b1, 4'h5};
         7'h7D:   return {1'b1, 4'h6};
         7'h07:   return {1'b1, 4'h7};
         7'h7F:   return {1'b1, 4'h8};
         7'h6F:   return {1'b1, 4'h9};
         7'h77:   return {1'b1, 4'hA};
         7'h7C:   return {1'b1, 4'hB};
         7'h39:   return {1'b1, 4'hC};
         7'h5E:   return {1'b1, 4'hD};
         7'h79:   return {1'b1, 4'hE};
         7'h71:   return {1'b1, 4'hF};
         default: return 5'b0;
      endcase
   endfunction

   assign changed   = (AN != s_an_q) || (SEG != s_seg_q);
   // fires once per stable period: the counter passes this value only once
   assign latch     = !changed && (cnt_q == CNT_W'(STABLE_CYCLES - 1));
   assign an_onehot = $onehot(~s_an_q);
   assign an_blank  = (s_an_q == 8'hFF);
   assign dec       = decode(~s_seg_q[6:0]);

   // digit index of the single low AN bit (only meaningful when an_onehot)
   always_comb begin
      idx = 3'd0;
      for (int i = 0; i < 8; i++)
         if (!s_an_q[i]) idx = 3'(i);
   end

   // stability counter and capture/frame next-state
   always_comb begin
      cnt_d     = changed ? '0 :
                  (cnt_q == CNT_W'(STABLE_CYCLES)) ? cnt_q : cnt_q + 1'b1;
      value_d   = value_q;
      dp_d      = dp_q;
      seen_d    = seen_q;
      fvalue_d  = fvalue_q;
      fdone_d   = 1'b0;
      seg_err_d = seg_err_q;
      an_err_d  = an_err_q;
      if (latch) begin
         if (an_onehot) begin
            if (dec[4]) begin
               value_d[{idx, 2'b00} +: 4] = dec[3:0];
               dp_d[idx]                  = ~s_seg_q[7];
               seen_d                     = seen_q | (8'h01 << idx);
               if (seen_d == 8'hFF) begin
                  fvalue_d = value_d;
                  fdone_d  = 1'b1;
                  seen_d   = 8'h00;
               end
            end else begin
               seg_err_d = 1'b1;
            end
         end else if (!an_blank) begin
            an_err_d = 1'b1;
         end
      end
   end

   // state registers; reset drops any partial frame
   always_ff @(posedge clk) begin
      if (RST) begin
         s_an_q    <= 8'hFF;
         s_seg_q   <= 8'hFF;
         cnt_q     <= '0;
         value_q   <= '0;
         dp_q      <= '0;
         seen_q    <= '0;
         fvalue_q  <= '0;
         fdone_q   <= 1'b0;
         seg_err_q <= 1'b0;
         an_err_q  <= 1'b0;
      end else begin
         s_an_q    <= AN;
         s_seg_q   <= SEG;
         cnt_q     <= cnt_d;
         value_q   <= value_d;
         dp_q      <= dp_d;
         seen_q    <= seen_d;
         fvalue_q  <= fvalue_d;
         fdone_q   <= fdone_d;
         seg_err_q <= seg_err_d;
         an_err_q  <= an_err_d;
      end
   end

   assign value       = value_q;
   assign dp          = dp_q;
   assign digit_seen  = seen_q;
   assign frame_value = fvalue_q;
   assign frame_done  = fdone_q;
   assign seg_error   = seg_err_q;
   assign an_error    = an_err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: directed scenarios plus random scan traffic,
// checked every cycle against a run-length based behavioural model.
module tb_seg_scan_capture;

   localparam int S = 4;

   logic        clk = 1'b0;
   logic        RST;
   logic [7:0]  SEG, AN;
   logic [31:0] value, frame_value;
   logic [7:0]  dp, digit_seen;
   logic        frame_done, seg_error, an_error;

   seg_scan_capture #(.STABLE_CYCLES(S)) dut (
      .clk(clk), .RST(RST), .SEG(SEG), .AN(AN),
      .value(value), .dp(dp), .digit_seen(digit_seen),
      .frame_value(frame_value), .frame_done(frame_done),
      .seg_error(seg_error), .an_error(an_error)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_fail = 0, fd_cnt = 0;
   bit started = 0;
   logic [6:0] gl [16];

   // model state
   logic [15:0] prev;
   int          run;
   logic [31:0] m_value, m_fv;
   logic [7:0]  m_dp, m_seen;
   logic        m_fd, m_se, m_ae;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // model: a slot is taken when the same AN/SEG pair has been sampled on
   // S+1 consecutive edges (application edge plus S more)
   always @(posedge clk) begin
      logic [7:0] a, s;
      int d, code;
      if (RST) begin
         started = 1;
         prev = 16'hFFFF; run = 1;
         m_value = 0; m_fv = 0; m_dp = 0; m_seen = 0;
         m_fd = 0; m_se = 0; m_ae = 0;
      end else begin
         if ({AN, SEG} == prev) begin
            if (run < 1000) run++;
         end else begin
            prev = {AN, SEG}; run = 1;
         end
         m_fd = 0;
         if (run == S + 1) begin
            a = prev[15:8]; s = prev[7:0];
            if ($countones(~a) == 1) begin
               d = 0;
               for (int k = 0; k < 8; k++) if (!a[k]) d = k;
               code = -1;
               for (int k = 0; k < 16; k++) if (gl[k] == ~s[6:0]) code = k;
               if (code >= 0) begin
                  m_value[4*d +: 4] = 4'(code);
                  m_dp[d] = ~s[7];
                  m_seen[d] = 1'b1;
                  if (m_seen == 8'hFF) begin
                     m_fv = m_value; m_fd = 1; m_seen = 0;
                  end
               end else m_se = 1;
            end else if ($countones(~a) > 1) m_ae = 1;
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (started) begin
         chk("value", value, m_value);
         chk("dp", {24'h0, dp}, {24'h0, m_dp});
         chk("digit_seen", {24'h0, digit_seen}, {24'h0, m_seen});
         chk("frame_value", frame_value, m_fv);
         chk("frame_done", {31'h0, frame_done}, {31'h0, m_fd});
         chk("seg_error", {31'h0, seg_error}, {31'h0, m_se});
         chk("an_error", {31'h0, an_error}, {31'h0, m_ae});
      end
   end

   task automatic hold(input logic [7:0] a, input logic [7:0] s, input int n);
      AN = a; SEG = s;
      repeat (n) begin
         @(negedge clk);
         if (frame_done) fd_cnt++;
      end
   endtask

   task automatic do_reset(input int n);
      RST = 1;
      repeat (n) @(negedge clk);
      RST = 0;
   endtask

   function automatic logic [7:0] dig(input int i);
      logic [7:0] one;
      one = 8'h01;
      return ~(one << i);
   endfunction

   function automatic logic [7:0] pat(input int n, input bit dpon);
      return ~{dpon, gl[n]};
   endfunction

   initial begin
      gl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      AN = 8'hFF; SEG = 8'hFF;
      RST = 1;
      @(negedge clk);
      do_reset(1);

      // 1: reset and blank
      hold(8'hFF, 8'hFF, 50);
      #1;
      chk("t1_value", value, 32'h0);
      chk("t1_seen", {24'h0, digit_seen}, 32'h0);
      chk("t1_frame_value", frame_value, 32'h0);
      chk("t1_errors", {30'h0, seg_error, an_error}, 32'h0);

      // 2: full frame 8,7,...,1
      fd_cnt = 0;
      for (int i = 0; i < 8; i++) hold(dig(i), pat(8 - i, 0), 6);
      hold(8'hFF, 8'hFF, 4);
      #1;
      chk("t2_pulses", fd_cnt, 1);
      chk("t2_frame_value", frame_value, 32'h12345678);
      chk("t2_seen", {24'h0, digit_seen}, 32'h0);

      // 3: latency boundary
      do_reset(1);
      hold(8'hFF, 8'hFF, 6);
      hold(8'hFE, ~8'h4F, 4);
      hold(8'hFF, 8'hFF, 6);
      #1;
      chk("t3_short_value", {28'h0, value[3:0]}, 32'h0);
      chk("t3_short_seen", {24'h0, digit_seen}, 32'h0);
      hold(8'hFE, ~8'h4F, 5);
      #1;
      chk("t3_long_value", {28'h0, value[3:0]}, 32'h3);

      // 4: decimal point and bad glyph
      hold(dig(2), pat(5, 0), 6);
      hold(dig(2), ~8'hBF, 6);
      hold(dig(3), ~8'h01, 6);
      #1;
      chk("t4_dp2", {31'h0, dp[2]}, 32'h1);
      chk("t4_nib2", {28'h0, value[11:8]}, 32'h0);
      chk("t4_seg_error", {31'h0, seg_error}, 32'h1);
      chk("t4_seen3", {31'h0, digit_seen[3]}, 32'h0);

      // 5: AN error and glitch
      do_reset(1);
      hold(8'hFF, 8'hFF, 4);
      hold(8'hFC, 8'hFF, 10);
      #1;
      chk("t5_an_error", {31'h0, an_error}, 32'h1);
      chk("t5_seen", {24'h0, digit_seen}, 32'h0);
      hold(dig(5), pat(10, 0), 3);
      hold(8'hFF, 8'hFF, 2);
      hold(dig(5), pat(10, 0), 4);
      #1;
      chk("t5_before", {28'h0, value[23:20]}, 32'h0);
      hold(dig(5), pat(10, 0), 1);
      #1;
      chk("t5_after", {28'h0, value[23:20]}, 32'hA);
      hold(dig(5), pat(10, 0), 4);

      // 6: reset mid-frame
      for (int i = 0; i < 5; i++) hold(dig(i), pat(9, 0), 6);
      do_reset(1);
      #1;
      chk("t6_seen_rst", {24'h0, digit_seen}, 32'h0);
      fd_cnt = 0;
      for (int i = 0; i < 8; i++) hold(dig(i), pat(15, 0), 6);
      hold(8'hFF, 8'hFF, 4);
      #1;
      chk("t6_pulses", fd_cnt, 1);
      chk("t6_frame_value", frame_value, 32'hFFFFFFFF);

      // random scan traffic
      begin
         int d = 0;
         for (int n = 0; n < 800; n++) begin
            int k;
            k = int'($urandom_range(0, 99));
            if (k < 70) begin
               hold(dig(d), pat(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1))),
                    int'($urandom_range(1, 8)));
               d = (d + 1) % 8;
            end else if (k < 80) hold(8'hFF, 8'hFF, int'($urandom_range(1, 8)));
            else if (k < 86) hold(dig(int'($urandom_range(0, 7))), 8'($urandom),
                                  int'($urandom_range(1, 8)));
            else if (k < 92) hold(8'($urandom) & 8'($urandom), 8'($urandom),
                                  int'($urandom_range(1, 8)));
            else if (k < 98) hold(AN, SEG ^ 8'h01, int'($urandom_range(1, 3)));
            else do_reset(1);
         end
      end
      hold(8'hFF, 8'hFF, 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
